// File: rtl/mat_result_serializer.sv
// Result-side sink for the 2x2 matrix multiplier: buffers done-qualified
// (w,x,y,z) tuples in a FIFO and streams them one element per cycle.
module mat_result_serializer #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                done,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         tuple_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  logic [4*W-1:0]      r_mem [DEPTH];
  logic [4*W-1:0]      r_hold;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic                r_valid;
  logic signed [W-1:0] r_data;
  logic [1:0]          r_idx;
  logic                r_last;
  logic                r_ovf;
  logic [15:0]         r_drop;
  logic [15:0]         r_tcnt;

  logic                w_fire;
  logic                w_end;
  logic                w_pop;
  logic                w_wr;
  logic [4*W-1:0]      w_head;

  // Tuples are packed w in the top slice down to z in the bottom slice.
  function automatic logic signed [W-1:0] f_elem(input logic [4*W-1:0] t,
                                                 input logic [1:0] i);
    case (i)
      2'd0:    return $signed(t[4*W-1:3*W]);
      2'd1:    return $signed(t[3*W-1:2*W]);
      2'd2:    return $signed(t[2*W-1:W]);
      default: return $signed(t[W-1:0]);
    endcase
  endfunction

  assign w_fire = r_valid & out_ready;
  assign w_end  = w_fire & (r_idx == 2'd3);
  assign w_pop  = (r_count != '0) & (~r_valid | w_end);
  assign w_wr   = done & ((r_count < CNT_FULL) | w_pop);
  assign w_head = r_mem[r_rptr];

  // Storage carries no reset; validity is tracked by the control state below.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w, x, y, z};
    if (w_pop) r_hold <= w_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= 2'd0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= 16'd0;
      r_tcnt  <= 16'd0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (done && !w_wr) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (w_end) r_tcnt <= r_tcnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_idx   <= 2'd0;
            r_data  <= f_elem(w_head, 2'd0);
            r_last  <= 1'b0;
          end
        end
        default: begin
          if (w_end) begin
            // Back-to-back tuples: reload straight from the FIFO head, no bubble.
            if (w_pop) begin
              r_idx  <= 2'd0;
              r_data <= f_elem(w_head, 2'd0);
              r_last <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_idx   <= 2'd0;
              r_last  <= 1'b0;
            end
          end else if (w_fire) begin
            r_idx  <= r_idx + 2'd1;
            r_data <= f_elem(r_hold, r_idx + 2'd1);
            r_last <= (r_idx == 2'd2);
          end
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;
  assign tuple_cnt = r_tcnt;

endmodule
